rr_sel4_sequencer: RTL and testbench

Four-channel round-robin select sequencer feeding the 2:4 decoder stage. It arbitrates four request lines and drives a registered 2-bit channel index plus a valid flag. It holds each grant until the consumer signals completion, the requester withdraws, or a hold timeout expires. `sel[1]` drives decoder input `a` and `sel[0]` drives decoder input `b`, gated downstream by `grant_valid`.

---
 rtl/rr_sel4_sequencer.sv | 66 ++++++
 tb/tb_rr_sel4_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rr_sel4_sequencer.sv
// rr_sel4_sequencer: four-channel round-robin grant sequencer with done/withdraw/timeout release.
module rr_sel4_sequencer #(
  parameter int HOLD_MAX = 16,
  parameter int CW = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       grant_valid,
  output logic       timeout,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CW-1:0] hold_lim = CW'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
  state_t state, state_n;
  logic [1:0] sel_n, last, last_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic to_n, hit, rel;
  // descending scan so the nearest channel after last overwrites the farther ones
  always_comb begin
    win = last;
    for (int i = 4; i >= 1; i--)
      if (req[last + 2'(i)]) win = last + 2'(i);
  end
  assign hit = (HOLD_MAX != 0) && (cnt == hold_lim);
  assign rel = done || !req[sel] || hit;
  always_comb begin
    state_n = state;
    sel_n = sel;
    cnt_n = cnt;
    last_n = last;
    to_n = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        sel_n = win;
        cnt_n = '0;
      end
    end else begin
      cnt_n = &cnt ? cnt : cnt + CW'(1);
      if (rel) begin
        state_n = IDLE;
        last_n = sel;
        to_n = hit && !done && req[sel];
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sel <= 2'b00;
      cnt <= '0;
      last <= 2'b11;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      cnt <= cnt_n;
      last <= last_n;
      timeout <= to_n;
    end
  assign grant_valid = (state == GRANT);
  assign busy = grant_valid;
endmodule

// File: tb/tb_rr_sel4_sequencer.sv
// tb_rr_sel4_sequencer: directed bench for rr_sel4_sequencer (HOLD_MAX=16 and HOLD_MAX=0 instances).
module tb_rr_sel4_sequencer;
  logic clk = 0, rst = 1, done = 0, done0 = 0;
  logic [3:0] req = 0, req0 = 0;
  logic [1:0] sel, sel0;
  logic gv, to, busy, gv0, to0, busy0;
  int checks = 0, errors = 0;

  rr_sel4_sequencer #(.HOLD_MAX(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant_valid(gv), .timeout(to), .busy(busy));
  rr_sel4_sequencer #(.HOLD_MAX(0), .CW(5)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .done(done0),
    .sel(sel0), .grant_valid(gv0), .timeout(to0), .busy(busy0));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; req = 0; done = 0;
    tick; tick;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
    checks++; if (gv !== 1'b0) begin errors++; $display("FAIL reset_gv got %0b want 0", gv); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", to); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst = 0;
    tick;
    checks++; if (gv !== 1'b0) begin errors++; $display("FAIL idle_noreq_gv got %0b want 0", gv); end
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (gv !== 1'b1 || sel !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant%0d got gv=%0b sel=%0d want gv=1 sel=%0d", k, gv, sel, k % 4); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy%0d got %0b want 1", k, busy); end
      done = 1;
      tick;
      done = 0;
      checks++; if (gv !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got gv=%0b to=%0b want 0 0", k, gv, to); end
    end
    req = 0;
    tick;
    checks++; if (gv !== 1'b0) begin errors++; $display("FAIL rr_end_gv got %0b want 0", gv); end
  endtask

  task automatic test_timeout;
    req = 4'b0100;
    tick;
    for (int c = 1; c <= 16; c++) begin
      checks++; if (gv !== 1'b1 || sel !== 2'd2 || to !== 1'b0) begin errors++; $display("FAIL to_hold%0d got gv=%0b sel=%0d to=%0b want 1 2 0", c, gv, sel, to); end
      if (c < 16) tick;
    end
    tick;
    checks++; if (gv !== 1'b0 || to !== 1'b1 || sel !== 2'd2) begin errors++; $display("FAIL to_pulse got gv=%0b to=%0b sel=%0d want 0 1 2", gv, to, sel); end
    tick;
    checks++; if (gv !== 1'b1 || to !== 1'b0 || sel !== 2'd2) begin errors++; $display("FAIL to_regrant got gv=%0b to=%0b sel=%0d want 1 0 2", gv, to, sel); end
    req = 0;
    tick;
    checks++; if (gv !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL to_withdraw got gv=%0b to=%0b want 0 0", gv, to); end
    tick;
  endtask

  task automatic test_withdraw;
    req = 4'b0010;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd1) begin errors++; $display("FAIL wd_grant got gv=%0b sel=%0d want 1 1", gv, sel); end
    tick; tick;
    checks++; if (gv !== 1'b1) begin errors++; $display("FAIL wd_cycle3 got gv=%0b want 1", gv); end
    req = 4'b0000;
    tick;
    checks++; if (gv !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL wd_release got gv=%0b to=%0b want 0 0", gv, to); end
    req = 4'b0011;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd0) begin errors++; $display("FAIL wd_wrap got gv=%0b sel=%0d want 1 0", gv, sel); end
    done = 1;
    tick;
    done = 0; req = 0;
    checks++; if (gv !== 1'b0) begin errors++; $display("FAIL wd_done got gv=%0b want 0", gv); end
    tick;
  endtask

  task automatic test_done_at_limit;
    req = 4'b0100;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd2) begin errors++; $display("FAIL lim_grant got gv=%0b sel=%0d want 1 2", gv, sel); end
    repeat (15) tick;
    checks++; if (gv !== 1'b1) begin errors++; $display("FAIL lim_cycle16 got gv=%0b want 1", gv); end
    done = 1;
    tick;
    done = 0; req = 0;
    checks++; if (gv !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL lim_coincide got gv=%0b to=%0b want 0 0", gv, to); end
    tick;
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b1000;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd3) begin errors++; $display("FAIL mr_grant got gv=%0b sel=%0d want 1 3", gv, sel); end
    #2 rst = 1;
    #1;
    checks++; if (gv !== 1'b0 || sel !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mr_async got gv=%0b sel=%0d busy=%0b want 0 0 0", gv, sel, busy); end
    tick;
    rst = 0;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd3) begin errors++; $display("FAIL mr_regrant got gv=%0b sel=%0d want 1 3", gv, sel); end
    req = 4'b1111;
    done = 1;
    tick;
    done = 0;
    tick;
    checks++; if (gv !== 1'b1 || sel !== 2'd0) begin errors++; $display("FAIL mr_next got gv=%0b sel=%0d want 1 0", gv, sel); end
    req = 0;
    tick; tick;
  endtask

  task automatic test_no_timeout;
    int bad_gv, bad_to;
    bad_gv = 0; bad_to = 0;
    req0 = 4'b0001;
    tick;
    checks++; if (gv0 !== 1'b1 || sel0 !== 2'd0) begin errors++; $display("FAIL nt_grant got gv=%0b sel=%0d want 1 0", gv0, sel0); end
    for (int c = 0; c < 100; c++) begin
      tick;
      if (gv0 !== 1'b1) bad_gv++;
      if (to0 !== 1'b0) bad_to++;
    end
    checks++; if (bad_gv != 0) begin errors++; $display("FAIL nt_hold got %0d dropped cycles want 0", bad_gv); end
    checks++; if (bad_to != 0) begin errors++; $display("FAIL nt_timeout got %0d pulses want 0", bad_to); end
    req0 = 0;
    tick;
    checks++; if (gv0 !== 1'b0 || to0 !== 1'b0) begin errors++; $display("FAIL nt_release got gv=%0b to=%0b want 0 0", gv0, to0); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_timeout;
    test_withdraw;
    test_done_at_limit;
    test_reset_mid_grant;
    test_no_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
